pipeline_hazard_ctrl: RTL and testbench

- Central sequencer for the 5-stage pipeline register chain (PC, IF/ID, ID/EX, EX/MEM, MEM/WB flipflops).
- Drives each pipeline register's `we` (hold) and a per-stage flush (bubble insert).
- Resolves load-use hazards, taken branches, multi-cycle mul/div and instruction/data memory wait handshakes.
- Maintains a stall-cycle performance counter.

---
 rtl/pipeline_hazard_ctrl.sv | 161 ++++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
//   Central sequencer for the 5-stage pipeline register chain. It drives a
//   write enable (hold) per register and a flush (bubble insert) per
//   post-PC register. It resolves data-memory waits, multi-cycle mul/div
//   occupancy of EX, load-use hazards, taken branches and instruction-fetch
//   waits, in that priority order. It also counts cycles in which the PC is
//   held.
//
// Ports
//   clk, reset          rising-edge clock, asynchronous active-low reset
//   id_rs, id_rt        source specifiers of the instruction in ID
//   ex_memread, ex_rt   EX holds a load, and the load's destination
//   ex_muldiv           EX holds a mul/div (level)
//   ex_branch_taken     branch/jump in EX resolved taken
//   if_req, imem_ack    fetch request / instruction word valid
//   mem_req, dmem_ack   MEM access request / data access completes
//   we_*                pipeline register write enables (PC .. MEM/WB)
//   flush_*             load an all-zero bubble on this edge
//   busy                controller is in a wait state
//   stall_count         cycles with we_pc==0 since reset (wraps)
module pipeline_hazard_ctrl #(
  parameter int MD_LATENCY = 32,
  parameter int REG_W      = 5,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             ex_memread,
  input  logic [REG_W-1:0] ex_rt,
  input  logic             ex_muldiv,
  input  logic             ex_branch_taken,
  input  logic             if_req,
  input  logic             imem_ack,
  input  logic             mem_req,
  input  logic             dmem_ack,
  output logic             we_pc,
  output logic             we_if_id,
  output logic             we_id_ex,
  output logic             we_ex_mem,
  output logic             we_mem_wb,
  output logic             flush_if_id,
  output logic             flush_id_ex,
  output logic             flush_ex_mem,
  output logic             flush_mem_wb,
  output logic             busy,
  output logic [CNT_W-1:0] stall_count
);

  // Stage indices into the packed enable/flush vectors.
  localparam int PC     = 0;
  localparam int IF_ID  = 1;
  localparam int ID_EX  = 2;
  localparam int EX_MEM = 3;
  localparam int MEM_WB = 4;

  localparam int MDW = $clog2(MD_LATENCY);
  // The cycle that launches the mul/div already counts as its first EX
  // cycle, so the register is loaded with MD_LATENCY-1 already decremented
  // once. The stall then releases in the cycle md_cnt reads zero, giving
  // exactly MD_LATENCY cycles of EX occupancy.
  localparam logic [MDW-1:0] MD_LOAD = MDW'(MD_LATENCY - 2);

  typedef enum logic [1:0] {RUN, MD_WAIT, DMEM_WAIT, IMEM_WAIT} state_t;

  state_t         state, state_nxt;
  logic [MDW-1:0] md_cnt, md_cnt_nxt;

  logic [MEM_WB:PC]    we_v;
  logic [MEM_WB:IF_ID] fl_v;

  logic data_wait, md_start, md_hold, md_active, load_use, fetch_wait;

  // Hazard conditions. A wait state only remembers that the handshake is
  // outstanding; the live request term detects a new wait on its first cycle.
  assign data_wait  = !dmem_ack && (mem_req || state == DMEM_WAIT);
  // ex_muldiv is a level that stays high while the op sits in EX, so it is
  // only a start condition outside MD_WAIT. It is also accepted straight out
  // of a data or fetch wait, because EX advances in those release cycles.
  assign md_start   = ex_muldiv && (state != MD_WAIT);
  assign md_hold    = (state == MD_WAIT) && (md_cnt != '0);
  assign md_active  = md_start || md_hold;
  assign load_use   = ex_memread && (ex_rt != '0) &&
                      ((ex_rt == id_rs) || (ex_rt == id_rt));
  assign fetch_wait = !imem_ack && (if_req || state == IMEM_WAIT);

  // State register, mul/div counter and stall counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= RUN;
      md_cnt      <= '0;
      stall_count <= '0;
    end else begin
      state  <= state_nxt;
      md_cnt <= md_cnt_nxt;
      if (!we_pc) stall_count <= stall_count + 1'b1;
    end
  end

  // Next state.
  always_comb begin
    state_nxt  = state;
    md_cnt_nxt = md_cnt;
    if (data_wait) begin
      // The whole front end is frozen: MD_WAIT keeps its count and
      // IMEM_WAIT keeps its pending fetch.
      if (state == RUN) state_nxt = DMEM_WAIT;
    end else if (md_start) begin
      state_nxt  = MD_WAIT;
      md_cnt_nxt = MD_LOAD;
    end else if (md_hold) begin
      md_cnt_nxt = md_cnt - 1'b1;
    end else if (ex_branch_taken) begin
      // The PC loads the branch target, so an outstanding fetch is dropped.
      state_nxt = RUN;
    end else if (fetch_wait) begin
      // A load-use stall does not cancel the fetch, so it is still tracked.
      state_nxt = IMEM_WAIT;
    end else begin
      state_nxt = RUN;
    end
  end

  // Outputs, highest priority first.
  always_comb begin
    we_v = '1;
    fl_v = '0;
    if (!reset) begin
      we_v = '0;
      fl_v = '1;
    end else if (data_wait) begin
      we_v[EX_MEM:PC] = '0;
      fl_v[MEM_WB]    = 1'b1;
    end else if (md_active) begin
      we_v[ID_EX:PC] = '0;
      fl_v[EX_MEM]   = 1'b1;
    end else if (load_use) begin
      we_v[IF_ID:PC] = '0;
      fl_v[ID_EX]    = 1'b1;
    end else if (ex_branch_taken) begin
      fl_v[IF_ID] = 1'b1;
      fl_v[ID_EX] = 1'b1;
    end else if (fetch_wait) begin
      we_v[PC]    = 1'b0;
      fl_v[IF_ID] = 1'b1;
    end
  end

  assign we_pc        = we_v[PC];
  assign we_if_id     = we_v[IF_ID];
  assign we_id_ex     = we_v[ID_EX];
  assign we_ex_mem    = we_v[EX_MEM];
  assign we_mem_wb    = we_v[MEM_WB];
  assign flush_if_id  = fl_v[IF_ID];
  assign flush_id_ex  = fl_v[ID_EX];
  assign flush_ex_mem = fl_v[EX_MEM];
  assign flush_mem_wb = fl_v[MEM_WB];
  assign busy         = (state != RUN);

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
module tb_pipeline_hazard_ctrl;
  localparam int LAT = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [4:0] id_rs = '0, id_rt = '0, ex_rt = '0;
  logic ex_memread = 0, ex_muldiv = 0, ex_branch_taken = 0;
  logic if_req = 0, imem_ack = 1, mem_req = 0, dmem_ack = 1;
  logic we_pc, we_if_id, we_id_ex, we_ex_mem, we_mem_wb;
  logic flush_if_id, flush_id_ex, flush_ex_mem, flush_mem_wb;
  logic busy;
  logic [31:0] stall_count;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.MD_LATENCY(LAT), .REG_W(5), .CNT_W(32)) dut (
    .clk(clk), .reset(reset),
    .id_rs(id_rs), .id_rt(id_rt), .ex_memread(ex_memread), .ex_rt(ex_rt),
    .ex_muldiv(ex_muldiv), .ex_branch_taken(ex_branch_taken),
    .if_req(if_req), .imem_ack(imem_ack), .mem_req(mem_req), .dmem_ack(dmem_ack),
    .we_pc(we_pc), .we_if_id(we_if_id), .we_id_ex(we_id_ex),
    .we_ex_mem(we_ex_mem), .we_mem_wb(we_mem_wb),
    .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
    .flush_ex_mem(flush_ex_mem), .flush_mem_wb(flush_mem_wb),
    .busy(busy), .stall_count(stall_count)
  );

  logic [4:0] we_o;
  logic [3:0] fl_o;
  assign we_o = {we_pc, we_if_id, we_id_ex, we_ex_mem, we_mem_wb};
  assign fl_o = {flush_if_id, flush_id_ex, flush_ex_mem, flush_mem_wb};

  int n_vec = 0;
  int n_bad = 0;

  // ctl = {memread, muldiv, branch, if_req, imem_ack, mem_req, dmem_ack}
  typedef struct {
    logic [4:0]  rs, rt, ert;
    logic [6:0]  ctl;
    logic [4:0]  we;
    logic [3:0]  fl;
    logic        busy;
    logic [31:0] cnt;
  } vec_t;

  vec_t tbl[29];

  function automatic vec_t mk(input logic [4:0] rs, input logic [4:0] rt,
                              input logic [4:0] ert, input logic [6:0] c,
                              input logic [4:0] we, input logic [3:0] fl,
                              input logic b, input int cnt);
    vec_t v;
    v.rs = rs; v.rt = rt; v.ert = ert; v.ctl = c;
    v.we = we; v.fl = fl; v.busy = b; v.cnt = 32'(cnt);
    return v;
  endfunction

  task automatic drive(input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] ert, input logic [6:0] c);
    id_rs = rs; id_rt = rt; ex_rt = ert;
    {ex_memread, ex_muldiv, ex_branch_taken, if_req, imem_ack, mem_req, dmem_ack} = c;
  endtask

  task automatic chk(input string name, input logic [4:0] ewe, input logic [3:0] efl,
                     input logic eb, input logic [31:0] ecnt);
    n_vec++;
    if (we_o !== ewe || fl_o !== efl || busy !== eb || stall_count !== ecnt) begin
      n_bad++;
      $display("FAIL %s: got we=%b fl=%b busy=%b cnt=%0d, want we=%b fl=%b busy=%b cnt=%0d",
               name, we_o, fl_o, busy, stall_count, ewe, efl, eb, ecnt);
    end
  endtask

  // Reference model: pending flags for each kind of wait plus the number
  // of EX cycles a running mul/div still has to spend, counting the current one.
  logic        m_md, m_dp, m_ip;
  int          m_left;
  logic [31:0] m_cnt;

  function automatic logic [8:0] m_out();
    logic dw, ms, lu, fw;
    logic [4:0] we;
    logic [3:0] fl;
    dw = !dmem_ack && (mem_req || m_dp);
    ms = (ex_muldiv && !m_md) || (m_md && m_left != 1);
    lu = ex_memread && ex_rt != 0 && (ex_rt == id_rs || ex_rt == id_rt);
    fw = !imem_ack && (if_req || m_ip);
    we = 5'b11111; fl = 4'b0000;
    if (dw)                   begin we = 5'b00001; fl = 4'b0001; end
    else if (ms)              begin we = 5'b00011; fl = 4'b0010; end
    else if (lu)              begin we = 5'b00111; fl = 4'b0100; end
    else if (ex_branch_taken) fl = 4'b1100;
    else if (fw)              begin we = 5'b01111; fl = 4'b1000; end
    return {we, fl};
  endfunction

  task automatic model_step(input logic exp_we_pc);
    logic dw, fw;
    dw = !dmem_ack && (mem_req || m_dp);
    fw = !imem_ack && (if_req || m_ip);
    if (!exp_we_pc) m_cnt = m_cnt + 1;
    if (dw) begin
      if (!m_md && !m_ip) m_dp = 1'b1;
    end else begin
      m_dp = 1'b0;
      if (ex_muldiv && !m_md) begin
        m_md = 1'b1; m_left = LAT - 1; m_ip = 1'b0;
      end else if (m_md && m_left != 1) begin
        m_left = m_left - 1;
      end else begin
        m_md = 1'b0;
        m_ip = !ex_branch_taken && fw;
      end
    end
  endtask

  localparam logic [6:0] IDLE = 7'b0000101;

  initial begin
    logic [8:0] e;
    tbl[0]  = mk(5, 0, 5, 7'b1000101, 5'b00111, 4'b0100, 0, 0);   // load-use on rs
    tbl[1]  = mk(1, 2, 0, IDLE,       5'b11111, 4'b0000, 0, 1);
    tbl[2]  = mk(0, 0, 0, 7'b1000101, 5'b11111, 4'b0000, 0, 1);   // ex_rt=0: no hazard
    tbl[3]  = mk(3, 7, 7, 7'b1000101, 5'b00111, 4'b0100, 0, 1);   // load-use on rt
    tbl[4]  = mk(1, 2, 0, 7'b0100101, 5'b00011, 4'b0010, 0, 2);   // mul/div start
    tbl[5]  = mk(1, 2, 0, 7'b0100101, 5'b00011, 4'b0010, 1, 3);
    tbl[6]  = mk(1, 2, 0, 7'b0100101, 5'b00011, 4'b0010, 1, 4);
    tbl[7]  = mk(1, 2, 0, 7'b0100101, 5'b11111, 4'b0000, 1, 5);   // 4th cycle releases
    tbl[8]  = mk(1, 2, 0, IDLE,       5'b11111, 4'b0000, 0, 5);
    tbl[9]  = mk(1, 2, 0, 7'b0000110, 5'b00001, 4'b0001, 0, 5);   // data wait x5
    tbl[10] = mk(1, 2, 0, 7'b0000110, 5'b00001, 4'b0001, 1, 6);
    tbl[11] = mk(1, 2, 0, 7'b0000110, 5'b00001, 4'b0001, 1, 7);
    tbl[12] = mk(1, 2, 0, 7'b0000110, 5'b00001, 4'b0001, 1, 8);
    tbl[13] = mk(1, 2, 0, 7'b0000110, 5'b00001, 4'b0001, 1, 9);
    tbl[14] = mk(1, 2, 0, 7'b0000111, 5'b11111, 4'b0000, 1, 10);  // ack releases
    tbl[15] = mk(1, 2, 0, IDLE,       5'b11111, 4'b0000, 0, 10);
    tbl[16] = mk(5, 1, 5, 7'b1010101, 5'b00111, 4'b0100, 0, 10);  // load-use beats branch
    tbl[17] = mk(1, 2, 0, 7'b0010101, 5'b11111, 4'b1100, 0, 11);  // branch next cycle
    tbl[18] = mk(1, 2, 0, 7'b0001001, 5'b01111, 4'b1000, 0, 11);  // fetch wait x3
    tbl[19] = mk(1, 2, 0, 7'b0001001, 5'b01111, 4'b1000, 1, 12);
    tbl[20] = mk(1, 2, 0, 7'b0001001, 5'b01111, 4'b1000, 1, 13);
    tbl[21] = mk(1, 2, 0, 7'b0011001, 5'b11111, 4'b1100, 1, 14);  // branch abandons fetch
    tbl[22] = mk(1, 2, 0, IDLE,       5'b11111, 4'b0000, 0, 14);
    tbl[23] = mk(1, 2, 0, 7'b0100101, 5'b00011, 4'b0010, 0, 14);  // mul/div start
    tbl[24] = mk(1, 2, 0, 7'b0100110, 5'b00001, 4'b0001, 1, 15);  // data wait freezes count
    tbl[25] = mk(1, 2, 0, 7'b0100101, 5'b00011, 4'b0010, 1, 16);
    tbl[26] = mk(1, 2, 0, 7'b0100101, 5'b00011, 4'b0010, 1, 17);
    tbl[27] = mk(1, 2, 0, 7'b0100101, 5'b11111, 4'b0000, 1, 18);
    tbl[28] = mk(1, 2, 0, IDLE,       5'b11111, 4'b0000, 0, 18);

    // Reset state
    drive(1, 2, 0, IDLE);
    @(negedge clk);
    chk("reset", 5'b00000, 4'b1111, 1'b0, 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;

    // Directed table
    for (int i = 0; i < 29; i++) begin
      drive(tbl[i].rs, tbl[i].rt, tbl[i].ert, tbl[i].ctl);
      @(negedge clk);
      chk($sformatf("tbl%0d", i), tbl[i].we, tbl[i].fl, tbl[i].busy, tbl[i].cnt);
      @(posedge clk);
      #1;
    end

    // Asynchronous reset in the middle of a mul/div wait
    drive(1, 2, 0, 7'b0100101);
    @(negedge clk);
    chk("md_start", 5'b00011, 4'b0010, 1'b0, 32'd18);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("md_wait", 5'b00011, 4'b0010, 1'b1, 32'd19);
    @(posedge clk);
    #2 reset = 1'b0;
    #1 chk("rst_async", 5'b00000, 4'b1111, 1'b0, 32'd0);
    @(posedge clk);
    #1 reset = 1'b1;
    drive(1, 2, 0, IDLE);
    @(negedge clk);
    chk("rst_release", 5'b11111, 4'b0000, 1'b0, 32'd0);
    @(posedge clk);
    #1;

    // Randomized stimulus against the reference model
    m_md = 0; m_dp = 0; m_ip = 0; m_left = 0; m_cnt = 0;
    for (int i = 0; i < 3000; i++) begin
      id_rs           = 5'($urandom_range(0, 3));
      id_rt           = 5'($urandom_range(0, 3));
      ex_rt           = 5'($urandom_range(0, 3));
      ex_memread      = ($urandom % 4) == 0;
      ex_muldiv       = ($urandom % 10) == 0;
      ex_branch_taken = ($urandom % 6) == 0;
      if_req          = ($urandom % 2) == 0;
      imem_ack        = ($urandom % 3) != 0;
      mem_req         = ($urandom % 3) == 0;
      dmem_ack        = ($urandom % 3) != 0;
      @(negedge clk);
      e = m_out();
      chk($sformatf("rand%0d", i), e[8:4], e[3:0], m_md | m_dp | m_ip, m_cnt);
      model_step(e[8]);
      @(posedge clk);
      #1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
